// File: rtl/pc_sequencer_if.sv
// Control bundle between the REDUX-V sequencer and its datapath.
// master = sequencer side, slave = datapath side.
interface pc_sequencer_if #(
  parameter int OP_BITS  = 4,
  parameter int CNT_BITS = 16
);
  logic [OP_BITS-1:0]  op;
  logic                zero;
  logic                mem_ready;
  logic                imem_req;
  logic                ir_we;
  logic                pc_we;
  logic                brzr_sel;
  logic                jmp_sel;
  logic                rf_we;
  logic                wb_sel;
  logic                dmem_re;
  logic                dmem_we;
  logic                halted;
  logic [CNT_BITS-1:0] retired;

  modport master (
    input  op, zero, mem_ready,
    output imem_req, ir_we, pc_we, brzr_sel, jmp_sel, rf_we, wb_sel,
           dmem_re, dmem_we, halted, retired
  );

  modport slave (
    output op, zero, mem_ready,
    input  imem_req, ir_we, pc_we, brzr_sel, jmp_sel, rf_we, wb_sel,
           dmem_re, dmem_we, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for REDUX-V,
// with a retired-instruction counter and a sticky HALT state.
module pc_sequencer #(
  parameter int OP_BITS  = 4,
  parameter int CNT_BITS = 16
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OP_BITS-1:0] OP_BRZR = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_JI   = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_LD   = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_ST   = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_HALT = '1;

  state_t              state, state_nxt;
  logic [OP_BITS-1:0]  op_q;
  logic [CNT_BITS-1:0] retired_q;

  logic imem_req, ir_we, pc_we, brzr_sel, jmp_sel;
  logic rf_we, wb_sel, dmem_re, dmem_we, halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= bus.op;
      if (pc_we) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    brzr_sel  = 1'b0;
    jmp_sel   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op_q)
          OP_BRZR: begin
            brzr_sel = bus.zero;
            pc_we    = 1'b1;
          end
          OP_JI: begin
            jmp_sel = 1'b1;
            pc_we   = 1'b1;
          end
          OP_LD, OP_ST: state_nxt = S_MEM;
          // PC is left untouched so it still points at the HALT word.
          OP_HALT: state_nxt = S_HALT;
          default: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        // Strobe held steady across wait states; only the exit depends on mem_ready.
        if (op_q == OP_ST) begin
          dmem_we = 1'b1;
          if (bus.mem_ready) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end
        end else begin
          dmem_re = 1'b1;
          if (bus.mem_ready) state_nxt = S_WB;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        wb_sel    = 1'b1;
        pc_we     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.brzr_sel = brzr_sel;
  assign bus.jmp_sel  = jmp_sel;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.dmem_re  = dmem_re;
  assign bus.dmem_we  = dmem_we;
  assign bus.halted   = halted;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-instruction expected cycle traces
// built from the opcode rules, with randomized ops, flags and wait states.
module tb_pc_sequencer;
  localparam int OPB = 4;
  localparam int CNTB = 8;  // narrow counter so wrap-around is reachable quickly

  localparam logic [9:0] IMEM = 10'h200, IRWE = 10'h100, PCWE = 10'h080,
                         BRZ  = 10'h040, JMP  = 10'h020, RFWE = 10'h010,
                         WBS  = 10'h008, DRE  = 10'h004, DWE  = 10'h002,
                         HLT  = 10'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.OP_BITS(OPB), .CNT_BITS(CNTB)) bus ();
  pc_sequencer #(.OP_BITS(OPB), .CNT_BITS(CNTB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] obs;
  assign obs = {bus.imem_req, bus.ir_we, bus.pc_we, bus.brzr_sel, bus.jmp_sel,
                bus.rf_we, bus.wb_sel, bus.dmem_re, bus.dmem_we, bus.halted};

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNTB-1:0] cnt = '0;  // model of instructions retired

  // One clock: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic mr, input logic z, input logic [9:0] exp, input string tag);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl obs=%h exp=%h", tag, obs, exp);
    end
    n_tests++;
    assert (bus.retired === cnt) else begin
      n_fail++;
      $error("FAIL %s retired obs=%h exp=%h", tag, bus.retired, cnt);
    end
    @(posedge clk);
    #1;
    if (exp & PCWE) cnt = cnt + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = '0;
  endtask

  function automatic logic [OPB-1:0] rnd_op();
    return OPB'($urandom_range(0, (1 << OPB) - 1));
  endfunction

  // Full instruction: fetch waits, decode, exec, then mem/wb as the opcode requires.
  task automatic run_instr(input logic [OPB-1:0] opv, input int fw, input int mw,
                           input logic zv, input string tag);
    logic z;
    bus.op = rnd_op();
    for (int i = 0; i < fw; i++) step(1'b0, 1'($urandom), IMEM, {tag, "_fwait"});
    step(1'b1, 1'($urandom), IMEM | IRWE, {tag, "_fetch"});
    bus.op = opv;
    step(1'($urandom), 1'($urandom), 10'h000, {tag, "_decode"});
    bus.op = rnd_op();  // live op must be ignored from here on
    case (opv)
      4'h0: begin
        z = zv;
        step(1'($urandom), z, PCWE | (z ? BRZ : 10'h000), {tag, "_brzr"});
      end
      4'h1: step(1'($urandom), 1'($urandom), PCWE | JMP, {tag, "_ji"});
      4'h2: begin
        step(1'($urandom), 1'($urandom), 10'h000, {tag, "_ld_exec"});
        for (int i = 0; i < mw; i++) step(1'b0, 1'($urandom), DRE, {tag, "_ld_wait"});
        step(1'b1, 1'($urandom), DRE, {tag, "_ld_mem"});
        step(1'($urandom), 1'($urandom), RFWE | WBS | PCWE, {tag, "_ld_wb"});
      end
      4'h3: begin
        step(1'($urandom), 1'($urandom), 10'h000, {tag, "_st_exec"});
        for (int i = 0; i < mw; i++) step(1'b0, 1'($urandom), DWE, {tag, "_st_wait"});
        step(1'b1, 1'($urandom), DWE | PCWE, {tag, "_st_mem"});
      end
      4'hF: step(1'($urandom), 1'($urandom), 10'h000, {tag, "_halt_exec"});
      default: step(1'($urandom), 1'($urandom), RFWE | PCWE, {tag, "_alu"});
    endcase
  endtask

  initial begin
    bus.op = 4'h5;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed sequence
    run_instr(4'h5, 0, 0, 1'b0, "alu");
    run_instr(4'h0, 0, 0, 1'b1, "brzr_z1");
    run_instr(4'h0, 0, 0, 1'b0, "brzr_z0");
    run_instr(4'h1, 0, 0, 1'b0, "ji");
    run_instr(4'h2, 0, 3, 1'b0, "ld_w3");
    run_instr(4'h3, 0, 0, 1'b0, "st");
    run_instr(4'hE, 2, 0, 1'b0, "alu_fw2");

    // Random mix long enough to wrap the counter
    for (int k = 0; k < 300; k++) begin
      logic [OPB-1:0] o;
      o = OPB'($urandom_range(0, 14));
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), "rnd");
    end

    // HALT: sticky, counter frozen, then reset recovers
    run_instr(4'hF, 1, 0, 1'b0, "halt");
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), HLT, "halted");
    do_reset();
    step(1'b0, 1'b0, IMEM, "post_halt_rst");
    run_instr(4'h7, 0, 0, 1'b0, "alu_after_halt");

    // Reset in the middle of an LD wait
    bus.op = 4'h2;
    step(1'b1, 1'b0, IMEM | IRWE, "mid_fetch");
    step(1'b0, 1'b0, 10'h000, "mid_decode");
    bus.op = 4'h5;
    step(1'b0, 1'b0, 10'h000, "mid_exec");
    step(1'b0, 1'b0, DRE, "mid_wait0");
    step(1'b0, 1'b0, DRE, "mid_wait1");
    do_reset();
    step(1'b0, 1'b0, IMEM, "mid_mem_rst");
    run_instr(4'h4, 0, 0, 1'b0, "alu_after_mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=none exp=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the REDUX-V core.
- Sequences fetch, decode, execute, memory and writeback, and drives the select/enable lines of the next-PC mux, the PC register, the IR, the register file and data memory.
- The next-PC mux passes the incremented PC by default, the branch target when its branch select is high, and the jump target when its jump select is high.
- Also counts retired instructions and stops in a HALT state.

Parameters:
- OP_BITS, 4, opcode field width taken from IR[7:4].
- CNT_BITS, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  OP_BITS  opcode field of the IR register output.
- zero  input  1  register-file flag: source register == 0.
- mem_ready  input  1  memory handshake; the current access completes this cycle.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  IR load enable.
- pc_we  output  1  PC load enable (loads next-PC mux output).
- brzr_sel  output  1  next-PC mux branch select.
- jmp_sel  output  1  next-PC mux jump select.
- rf_we  output  1  register-file write enable.
- wb_sel  output  1  writeback source: 0 = ALU, 1 = data memory.
- dmem_re  output  1  data memory read.
- dmem_we  output  1  data memory write.
- halted  output  1  core halted.
- retired  output  CNT_BITS  retired-instruction count.

Behaviour:
- Opcode map (4-bit):
  - 0x0 BRZR
  - 0x1 JI
  - 0x2 LD
  - 0x3 ST
  - 0x4..0xE ALU
  - 0xF HALT
- State register, 3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 are unreachable and go to FETCH on the next edge.
- Opcode register op_q: loaded from op in DECODE. EXEC, MEM and WB decode op_q only, never the live op input.
- Outputs are combinational from state, op_q, zero and mem_ready. Any output not listed as asserted in a state is 0.
- Reset: while rst=1 at an edge, state <= FETCH, op_q <= 0, retired <= 0. This applies from any state, including mid-MEM and HALT. In the cycle after reset every output is 0 except imem_req=1.
- FETCH:
  - imem_req=1.
  - If mem_ready: ir_we=1, go to DECODE. Otherwise stay in FETCH (wait states allowed, no timeout).
- DECODE: latch op_q, go to EXEC. No other outputs.
- EXEC, by op_q:
  - BRZR: brzr_sel=zero, pc_we=1, go to FETCH. zero=0 falls through to PC+1.
  - JI: jmp_sel=1, pc_we=1, go to FETCH.
  - ALU: rf_we=1, wb_sel=0, pc_we=1, go to FETCH.
  - LD or ST: go to MEM.
  - HALT: go to HALT; pc_we=0, so PC keeps the HALT address.
- MEM:
  - LD: dmem_re=1, held until mem_ready, then go to WB.
  - ST: dmem_we=1, held until mem_ready; in the mem_ready cycle pc_we=1, then go to FETCH.
  - Strobes stay constant throughout the wait.
- WB: rf_we=1, wb_sel=1, pc_we=1, go to FETCH.
- HALT: halted=1, all other outputs 0, stays until rst.
- Invariants:
  - brzr_sel and jmp_sel are never both 1.
  - dmem_re and dmem_we are never both 1.
  - pc_we is asserted exactly once per retired non-HALT instruction.
- retired increments by 1 at each edge where pc_we=1. It wraps from 2^CNT_BITS-1 to 0. HALT does not count.
- Latency with zero wait states:
  - ALU, BRZR, JI: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- mem_ready is ignored in DECODE, EXEC, WB and HALT.

Test Plan:
- Reset, mem_ready=1, op=0x5 (ALU) -> state sequence FETCH, DECODE, EXEC; in EXEC rf_we=1, wb_sel=0, pc_we=1, sel lines 00; retired=1 after 3 cycles.
- op=0x0, zero=1, then zero=0 -> EXEC brzr_sel=1, pc_we=1; second pass brzr_sel=0, jmp_sel=0, pc_we=1; op=0x1 gives jmp_sel=1, brzr_sel=0.
- op=0x2 with mem_ready low for 3 MEM cycles -> dmem_re=1 for 4 cycles, then WB with rf_we=1, wb_sel=1, pc_we=1; total latency 8 cycles.
- op=0x3, mem_ready=1 -> MEM asserts dmem_we=1 and pc_we=1 in the same cycle, dmem_re=0, rf_we never 1.
- op=0xF -> halted=1 from the cycle after EXEC with all other outputs 0 for 20 cycles and retired frozen; rst=1 -> FETCH, halted=0, retired=0.
- rst=1 asserted during an LD MEM wait, and preload retired to 0xFFFF then retire one ALU op -> after reset dmem_re=0, imem_req=1; counter wraps to 0x0000.
